// File: rtl/alu_seq_unit.sv
// Handshaked ALU execution unit: add/sub/and/or in one cycle, logical and
// arithmetic right shifts bit-serially, result held until the consumer takes it.
//
// state | meaning
// IDLE  | ready for a request (in_ready=1)
// SHIFT | serial shift in progress, one bit per cycle (busy=1)
// DONE  | result valid on C, waiting for out_ready
module alu_seq_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  ALUOp,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] C,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] work;
  logic [4:0]  cnt;
  logic        fill;
  logic [31:0] work_shr;

  assign work_shr  = {fill, work[31:1]};
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == SHIFT);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      C     <= '0;
      work  <= '0;
      cnt   <= '0;
      fill  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            case (ALUOp)
              3'b000: begin C <= A + B; state <= DONE; end
              3'b001: begin C <= A - B; state <= DONE; end
              3'b010: begin C <= A & B; state <= DONE; end
              3'b011: begin C <= A | B; state <= DONE; end
              3'b100, 3'b101: begin
                work <= A;
                cnt  <= B[4:0];
                fill <= ALUOp[0] & A[31];
                if (B[4:0] == 5'd0) begin
                  C     <= A;
                  state <= DONE;
                end else begin
                  state <= SHIFT;
                end
              end
              default: begin C <= '0; state <= DONE; end
            endcase
          end
        end
        SHIFT: begin
          // cnt is a down-counter; the last shift lands directly in C
          work <= work_shr;
          cnt  <= cnt - 5'd1;
          if (cnt == 5'd1) begin
            C     <= work_shr;
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_unit.sv
// Directed-vector bench for alu_seq_unit; inputs driven and outputs sampled
// on the falling edge so every check sees settled post-edge values.
module tb_alu_seq_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic [2:0]  ALUOp = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] C;
  logic        busy;

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;

  alu_seq_unit dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .ALUOp(ALUOp), .out_valid(out_valid), .out_ready(out_ready),
    .C(C), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One isolated request: checks busy-cycle count, result, and the release handshake.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] op, input logic [31:0] exp, input int exp_busy);
    int bc;
    int g;
    @(negedge clk);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    A = a; B = b; ALUOp = op; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    bc = 0; g = 0;
    while (!out_valid && g < 40) begin
      if (busy) bc++;
      g++;
      @(negedge clk);
    end
    chk({tag, "_busy_cycles"}, bc, exp_busy);
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_C"}, C, exp);
    chk({tag, "_in_ready_done"}, {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_released"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_idle"}, {31'd0, in_ready}, 32'd1);
    chk({tag, "_C_hold"}, C, exp);
  endtask

  logic [31:0] q_a   [4] = '{32'd5, 32'h0000_0F00, 32'h0000_0100, 32'd10};
  logic [31:0] q_b   [4] = '{32'd7, 32'h0000_00F0, 32'd2, 32'd3};
  logic [2:0]  q_op  [4] = '{3'b000, 3'b011, 3'b100, 3'b001};
  logic [31:0] q_exp [4] = '{32'd12, 32'h0000_0FF0, 32'h0000_0040, 32'd7};

  initial begin
    bit ov_seen;
    int stamp [4];
    int nres;

    // Power-on reset
    repeat (2) @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_C", C, 32'd0);
    reset = 1'b1;

    // Reset mid-shift discards the in-flight result
    @(negedge clk);
    A = 32'h8000_0000; B = 32'd10; ALUOp = 3'b101; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("midshift_busy", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    chk("mrst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("mrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    chk("mrst_C", C, 32'd0);
    ov_seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      ov_seen |= out_valid;
    end
    chk("mrst_no_stale_valid", {31'd0, ov_seen}, 32'd0);

    // Single-cycle ops
    run_op("add_1_1",  32'd1, 32'd1, 3'b000, 32'h0000_0002, 0);
    run_op("sub_1_2",  32'd1, 32'd2, 3'b001, 32'hFFFF_FFFF, 0);
    run_op("add_wrap", 32'hFFFF_FFFF, 32'd1, 3'b000, 32'h0000_0000, 0);
    run_op("or",       32'hA5A5_0000, 32'h0000_5A5A, 3'b011, 32'hA5A5_5A5A, 0);

    // Shifts
    run_op("sra_3",    32'h8000_0000, 32'd3, 3'b101, 32'hF000_0000, 3);
    run_op("srl_3",    32'h8000_0000, 32'd3, 3'b100, 32'h1000_0000, 3);
    run_op("sra_23",   32'h8000_0000, 32'h0000_0023, 3'b101, 32'hF000_0000, 3);
    run_op("srl_23",   32'h8000_0000, 32'h0000_0023, 3'b100, 32'h1000_0000, 3);
    run_op("sra_0",    32'h9234_5678, 32'h0000_0020, 3'b101, 32'h9234_5678, 0);
    run_op("sra_31",   32'h8000_0001, 32'd31, 3'b101, 32'hFFFF_FFFF, 31);
    run_op("srl_31",   32'h8000_0001, 32'd31, 3'b100, 32'h0000_0001, 31);
    run_op("rsvd_110", 32'h1234_5678, 32'd9, 3'b110, 32'h0000_0000, 0);
    run_op("sra_pos",  32'h4000_0000, 32'd4, 3'b101, 32'h0400_0000, 4);
    run_op("rsvd_111", 32'hFFFF_FFFF, 32'd1, 3'b111, 32'h0000_0000, 0);

    // Backpressure: result held while out_ready is low, new requests ignored
    @(negedge clk);
    A = 32'hF0F0_F0F0; B = 32'hFF00_FF00; ALUOp = 3'b010; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_valid0", {31'd0, out_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      A = 32'h0000_1111 * (i + 1); B = 32'd3; ALUOp = 3'b000; in_valid = ~i[0];
      @(negedge clk);
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_C", C, 32'hF000_F000);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_release", {31'd0, out_valid}, 32'd0);
    chk("bp_idle", {31'd0, in_ready}, 32'd1);
    chk("bp_C_hold", C, 32'hF000_F000);

    // Back-to-back with in_valid held high and out_ready held high
    out_ready = 1'b1;
    nres = 0;
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          int g;
          A = q_a[i]; B = q_b[i]; ALUOp = q_op[i]; in_valid = 1'b1;
          g = 0;
          while (!in_ready && g < 50) begin
            @(negedge clk);
            g++;
          end
          @(negedge clk);
        end
        in_valid = 1'b0;
      end
      begin
        for (int t = 0; t < 100 && nres < 4; t++) begin
          @(negedge clk);
          if (out_valid) begin
            chk("b2b_no_accept", {31'd0, in_ready}, 32'd0);
            chk("b2b_C", C, q_exp[nres]);
            stamp[nres] = cyc;
            nres++;
          end
        end
      end
    join
    out_ready = 1'b0;
    chk("b2b_count", nres, 32'd4);
    if (nres >= 2) chk("b2b_throughput", stamp[1] - stamp[0], 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/alu_seq_unit.md
# alu_seq_unit

Handshaked, registered ALU execution unit that responds to operation requests from an upstream initiator (datapath controller or testbench driver) and returns one result per request. It implements the team's 3-bit ALUOp encoding. Add, subtract, AND and OR complete in one cycle. Logical and arithmetic right shifts run bit-serially, one position per cycle. The unit sits between the issue logic and the write-back register, and holds each result until the consumer accepts it.

## Interface
- No parameters; data width fixed at 32.
- clk  in  1  system clock, rising-edge.
- reset  in  1  synchronous, active-low reset; sampled on rising edge of clk.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept a request.
- A  in  32  operand A.
- B  in  32  operand B; shift amount is B[4:0].
- ALUOp  in  3  000 A+B, 001 A-B, 010 A&B, 011 A|B, 100 A>>B (logical), 101 A>>>B (arithmetic), 110/111 reserved.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- C  out  32  result, registered.
- busy  out  1  high in SHIFT state.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: in_ready=1. A request is accepted when in_valid&&in_ready at a clock edge. Operands are ignored otherwise.
- On acceptance with ALUOp 000/001/010/011:
  - C <= result, next state DONE.
  - Add/sub wrap modulo 2^32; no carry or overflow output.
- On acceptance with ALUOp 100/101:
  - Working register <= A, count <= B[4:0], fill bit <= (ALUOp==101) ? A[31] : 0.
  - If B[4:0]==0: C <= A, next state DONE.
  - Otherwise next state SHIFT.
  - B[31:5] is ignored.
- SHIFT: on each edge, the working register shifts right by 1 with the fill bit inserted at bit 31, and count decrements. When count goes from 1 to 0: C <= shifted value, next state DONE.
- Reserved ALUOp: accepted, C <= 0, next state DONE.
- DONE: out_valid=1, C stable. When out_ready is high at an edge, the unit returns to IDLE.
- in_ready=0 in SHIFT and DONE. A request cannot be accepted in the cycle its predecessor's result is accepted; the earliest new acceptance is the following edge.
- in_valid held high while in_ready=0 has no effect. The initiator must keep A/B/ALUOp stable until acceptance.

## Timing
- Reset (reset==0 at an edge): state IDLE, in_ready=1 after edge, out_valid=0, busy=0, C=0, working register and count cleared.
- Reset overrides everything, including mid-SHIFT and in DONE with a pending result. The in-flight result is discarded; out_valid is never asserted for it.
- Latency, with acceptance at edge k:
  - Single-cycle ops and shift-by-0: out_valid=1 after edge k.
  - Shift by n (1..31): busy=1 after edges k..k+n-1, out_valid=1 after edge k+n.
- Throughput, with out_ready held high: one single-cycle op every 2 cycles.
- out_valid deasserts after the edge where out_ready is sampled high. C keeps its value until the next result is written.
- All outputs are registered or decoded from state only; there is no combinational path from any input to any output.

## Test plan
- Reset: hold reset=0 for 2 edges mid-SHIFT (A=0x80000000, B=10, ALUOp=101) -> after release: in_ready=1, out_valid=0, C=0, busy=0.
- Add/sub: A=1,B=1,op=000 -> C=0x00000002, out_valid 1 cycle after acceptance. A=1,B=2,op=001 -> C=0xFFFFFFFF. A=0xFFFFFFFF,B=1,op=000 -> C=0.
- Shifts:
  - A=0x80000000, B=3, op=101 -> C=0xF0000000 after 3 busy cycles.
  - Same operands, op=100 -> C=0x10000000.
  - B=0x00000023 (B[4:0]=3) -> same results as B=3.
  - B=0 -> C=A, 1-cycle latency.
- Backpressure: op=010 with A=0xF0F0F0F0, B=0xFF00FF00, out_ready=0 for 5 cycles -> out_valid and C=0xF000F000 stable, in_ready=0, in_valid pulses ignored. Then out_ready=1 -> IDLE next edge.
- Max shift / reserved ops:
  - A=0x80000001, B=31, op=101 -> C=0xFFFFFFFF after 31 busy cycles.
  - op=100, same operands -> C=0x00000001.
  - op=110 -> C=0.
- Back-to-back: in_valid held high with 4 queued requests (add, or, srl by 2, sub), out_ready=1 -> results in order, with no acceptance while out_valid=1.
